// File: rtl/seq_basics_pkg.sv
// Shared types for the sequential_basics primitives.
//   sr_mode_t : shift register operation selected each clock edge.
package seq_basics_pkg;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_LEFT  = 2'd1,
    SR_RIGHT = 2'd2,
    SR_LOAD  = 2'd3
  } sr_mode_t;

endpackage

// File: rtl/seq_basics_param_mod_counter.sv
// mod_counter: modulo-CNT_MOD up/down counter with saturating load and wrap flag.
// Ports:
//   clk50m, rst       clock, synchronous active-high reset
//   cnt_en, cnt_up    count enable / direction (1 = up)
//   cnt_load, cnt_din synchronous load (wins over cnt_en), load value
//   cnt               counter value, always in 0..CNT_MOD-1
//   cnt_zero          cnt == 0, combinational from the register
//   cnt_wrap          registered pulse: cnt wrapped on the previous edge
module mod_counter #(
  parameter int CNT_WIDTH = 4,
  parameter int CNT_MOD   = 10
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic                 cnt_en,
  input  logic                 cnt_up,
  input  logic                 cnt_load,
  input  logic [CNT_WIDTH-1:0] cnt_din,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 cnt_zero,
  output logic                 cnt_wrap
);

  if (CNT_WIDTH < 1) begin : g_bad_width
    $error("mod_counter: CNT_WIDTH must be >= 1");
  end
  if (CNT_MOD < 2 || CNT_MOD > (1 << CNT_WIDTH)) begin : g_bad_mod
    $error("mod_counter: CNT_MOD must be in 2..2**CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CNT_MOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // One extra bit so CNT_MOD == 2**CNT_WIDTH is representable.
  localparam logic [CNT_WIDTH:0]   CNT_MOD_X = (CNT_WIDTH+1)'(CNT_MOD);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (cnt_load) begin
      // Out-of-range load values saturate; a load never flags a wrap.
      cnt_d = ({1'b0, cnt_din} < CNT_MOD_X) ? cnt_din : CNT_MAX;
    end else if (cnt_en) begin
      if (cnt_up) begin
        // Explicit terminal compare so natural rollover still flags wrap.
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = CNT_MAX;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_wrap = wrap_q;

endmodule

// File: rtl/seq_basics_param.sv
// seq_basics_param: D-FF with enable, universal shift register and
// modulo counter, all on clk50m with synchronous active-high reset.
// Ports:
//   d_en, d, q                 enabled D flip-flop
//   sr_mode, sin, sr_pdata, sr shift register (HOLD/LEFT/RIGHT/LOAD)
//   cnt_en, cnt_up, cnt_load, cnt_din, cnt, cnt_zero, cnt_wrap  counter
module seq_basics_param
  import seq_basics_pkg::*;
#(
  parameter int SR_WIDTH  = 8,
  parameter int CNT_WIDTH = 4,
  parameter int CNT_MOD   = 10
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic                 d_en,
  input  logic                 d,
  output logic                 q,
  input  logic [1:0]           sr_mode,
  input  logic                 sin,
  input  logic [SR_WIDTH-1:0]  sr_pdata,
  output logic [SR_WIDTH-1:0]  sr,
  input  logic                 cnt_en,
  input  logic                 cnt_up,
  input  logic                 cnt_load,
  input  logic [CNT_WIDTH-1:0] cnt_din,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 cnt_zero,
  output logic                 cnt_wrap
);

  if (SR_WIDTH < 2) begin : g_bad_sr
    $error("seq_basics_param: SR_WIDTH must be >= 2");
  end

  sr_mode_t mode;
  assign mode = sr_mode_t'(sr_mode);

  logic                q_q, q_d;
  logic [SR_WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    q_d = q_q;
    if (d_en) q_d = d;
  end

  always_comb begin
    sr_d = sr_q;
    unique case (mode)
      SR_HOLD:  sr_d = sr_q;
      SR_LEFT:  sr_d = {sr_q[SR_WIDTH-2:0], sin};
      SR_RIGHT: sr_d = {sin, sr_q[SR_WIDTH-1:1]};
      SR_LOAD:  sr_d = sr_pdata;
      default:  sr_d = sr_q;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  always_ff @(posedge clk50m) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q  = q_q;
  assign sr = sr_q;

  mod_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .CNT_MOD   (CNT_MOD)
  ) u_cnt (
    .clk50m   (clk50m),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .cnt_up   (cnt_up),
    .cnt_load (cnt_load),
    .cnt_din  (cnt_din),
    .cnt      (cnt),
    .cnt_zero (cnt_zero),
    .cnt_wrap (cnt_wrap)
  );

endmodule

// File: tb/tb_seq_basics_param.sv
module tb_seq_basics_param;

  logic       clk50m = 1'b0;
  logic       rst, d_en, d, sin, cnt_en, cnt_up, cnt_load;
  logic [1:0] sr_mode;
  logic [7:0] sr_pdata;
  logic [3:0] cnt_din;

  logic       q_a, q_b;
  logic [7:0] sr_a, sr_b;
  logic [3:0] cnt_a, cnt_b;
  logic       z_a, z_b, w_a, w_b;

  always #10 clk50m = ~clk50m;

  // Modulus-10 instance (default) and modulus-16 instance (full rollover).
  seq_basics_param #(.SR_WIDTH(8), .CNT_WIDTH(4), .CNT_MOD(10)) u_dut10 (
    .clk50m(clk50m), .rst(rst), .d_en(d_en), .d(d), .q(q_a),
    .sr_mode(sr_mode), .sin(sin), .sr_pdata(sr_pdata), .sr(sr_a),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load), .cnt_din(cnt_din),
    .cnt(cnt_a), .cnt_zero(z_a), .cnt_wrap(w_a));

  seq_basics_param #(.SR_WIDTH(8), .CNT_WIDTH(4), .CNT_MOD(16)) u_dut16 (
    .clk50m(clk50m), .rst(rst), .d_en(d_en), .d(d), .q(q_b),
    .sr_mode(sr_mode), .sin(sin), .sr_pdata(sr_pdata), .sr(sr_b),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load), .cnt_din(cnt_din),
    .cnt(cnt_b), .cnt_zero(z_b), .cnt_wrap(w_b));

  typedef struct {
    logic       rst, d_en, d, sin, cnt_en, cnt_up, cnt_load;
    logic [1:0] mode;
    logic [7:0] pd;
    logic [3:0] din;
  } stim_t;

  typedef struct {
    int q, sr, ca, wa, cb, wb;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: plain integers, modular arithmetic.
  int m_q, m_sr, m_ca, m_wa, m_cb, m_wb;

  function automatic void cnt_model(input int md, input int c, input stim_t s,
                                    output int nc, output int nw);
    nw = 0;
    nc = c;
    if (s.cnt_load)            nc = (int'(s.din) < md) ? int'(s.din) : md - 1;
    else if (s.cnt_en && s.cnt_up) begin
      nc = (c + 1) % md;  nw = (c + 1 == md) ? 1 : 0;
    end else if (s.cnt_en) begin
      nc = (c + md - 1) % md;  nw = (c == 0) ? 1 : 0;
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.d_en = 0; s.d = 0; s.sin = 0; s.cnt_en = 0; s.cnt_up = 0;
    s.cnt_load = 0; s.mode = 2'd0; s.pd = 8'h00; s.din = 4'd0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int nc, nw;
    @(negedge clk50m);
    rst = s.rst; d_en = s.d_en; d = s.d; sin = s.sin; sr_mode = s.mode;
    sr_pdata = s.pd; cnt_en = s.cnt_en; cnt_up = s.cnt_up;
    cnt_load = s.cnt_load; cnt_din = s.din;
    if (s.rst) begin
      m_q = 0; m_sr = 0; m_ca = 0; m_wa = 0; m_cb = 0; m_wb = 0;
    end else begin
      if (s.d_en) m_q = int'(s.d);
      case (s.mode)
        2'd1: m_sr = ((m_sr * 2) + int'(s.sin)) % 256;
        2'd2: m_sr = (int'(s.sin) * 128) + (m_sr / 2);
        2'd3: m_sr = int'(s.pd);
        default: ;
      endcase
      cnt_model(10, m_ca, s, nc, nw); m_ca = nc; m_wa = nw;
      cnt_model(16, m_cb, s, nc, nw); m_cb = nc; m_wb = nw;
    end
    e.q = m_q; e.sr = m_sr; e.ca = m_ca; e.wa = m_wa; e.cb = m_cb; e.wb = m_wb;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge presents new outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk50m);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("q",        32'(q_a),  32'(e.q));
        chk("q16",      32'(q_b),  32'(e.q));
        chk("sr",       32'(sr_a), 32'(e.sr));
        chk("sr16",     32'(sr_b), 32'(e.sr));
        chk("cnt",      32'(cnt_a), 32'(e.ca));
        chk("cnt_zero", 32'(z_a),  32'(e.ca == 0));
        chk("cnt_wrap", 32'(w_a),  32'(e.wa));
        chk("cnt16",    32'(cnt_b), 32'(e.cb));
        chk("zero16",   32'(z_b),  32'(e.cb == 0));
        chk("wrap16",   32'(w_b),  32'(e.wb));
      end
    end
  end

  initial begin
    stim_t s;
    int    budget;
    rst = 1; d_en = 0; d = 0; sin = 0; sr_mode = 2'd0; sr_pdata = 8'h00;
    cnt_en = 0; cnt_up = 0; cnt_load = 0; cnt_din = 4'd0;

    // Reset held with every enable active.
    s = idle(); s.rst = 1; s.d_en = 1; s.d = 1; s.sin = 1; s.mode = 2'd3;
    s.pd = 8'hFF; s.cnt_en = 1; s.cnt_up = 1; s.cnt_load = 1; s.din = 4'd7;
    repeat (3) step(s);

    // Shift register: load, left, right, hold.
    s = idle(); s.mode = 2'd3; s.pd = 8'hA5; step(s);
    s = idle(); s.mode = 2'd1; s.sin = 1;    step(s);
    s = idle(); s.mode = 2'd2; s.sin = 0;    step(s);
    s = idle(); repeat (3) step(s);

    // Count up through one full period, then down across zero.
    s = idle(); s.cnt_en = 1; s.cnt_up = 1; repeat (10) step(s);
    s = idle(); s.cnt_en = 1; s.cnt_up = 0; step(s);
    s = idle(); s.cnt_en = 1; s.cnt_load = 1; s.din = 4'd14; step(s);

    // Top-of-range load then natural rollover; D-FF hold with d toggling.
    s = idle(); s.cnt_load = 1; s.din = 4'd15; s.d_en = 1; s.d = 1; step(s);
    s = idle(); s.cnt_en = 1; s.cnt_up = 1; step(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.d = i[0]; step(s);
    end

    // Reset pulse mid-count, then resume.
    s = idle(); s.cnt_load = 1; s.din = 4'd5; s.mode = 2'd3; s.pd = 8'hFF; step(s);
    s = idle(); s.rst = 1; s.cnt_en = 1; s.cnt_up = 1; step(s);
    s = idle(); s.cnt_en = 1; s.cnt_up = 1; repeat (3) step(s);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s.rst      = ($urandom_range(0, 31) == 0);
      s.d_en     = 1'($urandom);
      s.d        = 1'($urandom);
      s.sin      = 1'($urandom);
      s.mode     = 2'($urandom);
      s.pd       = 8'($urandom);
      s.cnt_en   = ($urandom_range(0, 3) != 0);
      s.cnt_up   = 1'($urandom);
      s.cnt_load = ($urandom_range(0, 7) == 0);
      s.din      = 4'($urandom);
      step(s);
    end

    budget = 0;
    while (sbq.size() > 0 && budget < 5) begin
      @(negedge clk50m);
      budget++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
